// File: rtl/ardunio_tick_tx.sv
// Tick-line transmitter: emits a burst of timed pulses to the Arduino and
// mirrors the far-end 0..5 receive counter in shadow_cnt.
module ardunio_tick_tx #(
  parameter int HIGH_CYCLES = 50000,
  parameter int LOW_CYCLES  = 50000,
  parameter int TIMER_W     = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] burst_len,
  input  logic       sync_clr,
  output logic       busy,
  output logic       done,
  output logic       tick,
  output logic [2:0] shadow_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [TIMER_W-1:0] HI_LD = TIMER_W'(HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LO_LD = TIMER_W'(LOW_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         rem_q, rem_d;
  logic [2:0]         shad_q, shad_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  function automatic logic [2:0] shad_adv(input logic [2:0] v);
    return (v == 3'd5) ? 3'd0 : v + 3'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    shad_d  = shad_q;
    tick_d  = tick_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != 3'd0) begin
            rem_d   = burst_len - 3'd1;
            timer_d = HI_LD;
            tick_d  = 1'b1;
            busy_d  = 1'b1;
            shad_d  = shad_adv(shad_q);
            state_d = S_HIGH;
          end else begin
            state_d = S_DONE;
          end
        end else if (sync_clr) begin
          shad_d = 3'd0;
        end
      end
      S_HIGH: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else begin
          tick_d  = 1'b0;
          timer_d = LO_LD;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (rem_q == 3'd0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          rem_d   = rem_q - 3'd1;
          tick_d  = 1'b1;
          timer_d = HI_LD;
          shad_d  = shad_adv(shad_q);
          state_d = S_HIGH;
        end
      end
      S_DONE: begin
        // A zero-length request enters DONE with done low; it spends one
        // more cycle here to raise done before returning to IDLE.
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rem_q   <= 3'd0;
      shad_q  <= 3'd0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      shad_q  <= shad_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign tick       = tick_q;
  assign shadow_cnt = shad_q;

endmodule

// File: tb/tb_ardunio_tick_tx.sv
// Bench for ardunio_tick_tx: a transaction-level timing model predicts every
// output cycle by cycle; directed scenarios add hand-computed pins.
module tb_ardunio_tick_tx;
  localparam int H = 3;
  localparam int L = 2;
  localparam int P = H + L;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] burst_len = 3'd0;
  logic       sync_clr = 1'b0;
  logic       busy, done, tick;
  logic [2:0] shadow_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ardunio_tick_tx #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .TIMER_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .sync_clr(sync_clr), .busy(busy), .done(done), .tick(tick),
    .shadow_cnt(shadow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: a request accepted at edge k is described by c = edges since k.
  bit m_act = 0;
  int m_c, m_n, m_end;
  int m_base, m_shadow = 0;
  int e_busy = 0, e_done = 0, e_tick = 0, e_shadow = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_shadow = 0;
      e_busy = 0; e_done = 0; e_tick = 0; e_shadow = 0;
    end else begin
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_c = 0; m_n = int'(burst_len); m_base = m_shadow;
          m_end = (m_n == 0) ? 1 : m_n * P;
        end else if (sync_clr) begin
          m_shadow = 0;
        end
      end else begin
        m_c++;
      end
      e_done = 0; e_busy = 0; e_tick = 0;
      if (m_act) begin
        if (m_c < m_n * P) begin
          e_busy = 1;
          e_tick = ((m_c % P) < H) ? 1 : 0;
          m_shadow = (m_base + m_c / P + 1) % 6;
        end else begin
          m_shadow = (m_base + m_n) % 6;
          e_done = (m_c == m_end) ? 1 : 0;
          if (m_c == m_end + 1) m_act = 0;
        end
      end
      e_shadow = m_shadow;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("tick", int'(tick), e_tick);
      chk("shadow_cnt", int'(shadow_cnt), e_shadow);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int r_rise, r_busy, r_done, r_done_at;

  // Issue a request and observe ncyc cycles starting at the accepting edge.
  // At cycle inj a conflicting request plus sync_clr is injected for 2 cycles.
  task automatic burst(input int len, input int ncyc, input int inj);
    logic prev;
    prev = tick;
    r_rise = 0; r_busy = 0; r_done = 0; r_done_at = -1;
    start = 1'b1; burst_len = 3'(len);
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      if (i == 0) start = 1'b0;
      if (i == inj) begin start = 1'b1; burst_len = 3'd5; sync_clr = 1'b1; end
      if (i == inj + 2) begin start = 1'b0; sync_clr = 1'b0; end
      if (tick && !prev) r_rise++;
      if (busy) r_busy++;
      if (done) begin r_done++; if (r_done_at < 0) r_done_at = i; end
      prev = tick;
    end
  endtask

  initial begin
    // Reset held with start asserted.
    start = 1'b1; burst_len = 3'd3;
    repeat (3) cyc();
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_shadow", int'(shadow_cnt), 0);
    start = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Single pulse.
    burst(1, 8, -1);
    chk("single_rise", r_rise, 1);
    chk("single_busy", r_busy, 5);
    chk("single_done", r_done, 1);
    chk("single_done_at", r_done_at, 5);
    chk("single_shadow", int'(shadow_cnt), 1);

    // Full burst with wrap from 0.
    sync_clr = 1'b1; cyc(); sync_clr = 1'b0;
    chk("clr_shadow", int'(shadow_cnt), 0);
    burst(7, 38, -1);
    chk("full_rise", r_rise, 7);
    chk("full_busy", r_busy, 35);
    chk("full_done_at", r_done_at, 35);
    chk("full_shadow", int'(shadow_cnt), 1);

    // Zero length.
    burst(0, 4, -1);
    chk("zero_rise", r_rise, 0);
    chk("zero_busy", r_busy, 0);
    chk("zero_done", r_done, 1);
    chk("zero_done_at", r_done_at, 1);
    chk("zero_shadow", int'(shadow_cnt), 1);

    // Inputs ignored mid-burst.
    burst(2, 14, 2);
    chk("ign_rise", r_rise, 2);
    chk("ign_done", r_done, 1);
    chk("ign_shadow", int'(shadow_cnt), 3);

    // Reset during the HIGH phase of pulse 2.
    burst(3, 7, -1);
    chk("mid_pre_tick", int'(tick), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_tick", int'(tick), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_shadow", int'(shadow_cnt), 0);
    repeat (2) cyc();
    chk("mid_done", int'(done), 0);
    rst_n = 1'b1;
    cyc();
    burst(1, 8, -1);
    chk("post_rise", r_rise, 1);
    chk("post_done_at", r_done_at, 5);
    chk("post_shadow", int'(shadow_cnt), 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      burst_len = 3'($urandom_range(0, 7));
      sync_clr  = ($urandom_range(0, 4) == 0);
      cyc();
    end
    start = 1'b0; sync_clr = 1'b0;
    repeat (50) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
